// File: rtl/day_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : day_timer_multi
//  Description : Minute-of-day timer. Prescales clk into minute ticks, counts
//                minutes over a programmable day length, pulses day_end on
//                wrap, counts days, and raises per-channel alarm pulses.
//                Supports enable/pause and a synchronous preload.
//  Revision    : 1.0 - initial release
// ============================================================================
module day_timer_multi #(
  parameter int WIDTH    = 11,
  parameter int TICK_DIV = 1,
  parameter int N_ALARMS = 4,
  parameter int DAY_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [N_ALARMS*WIDTH-1:0] alarm_time,
  input  logic [N_ALARMS-1:0]       alarm_en,
  output logic                      tick,
  output logic [WIDTH-1:0]          time_out,
  output logic                      day_end,
  output logic [DAY_W-1:0]          day_count,
  output logic [N_ALARMS-1:0]       alarm_hit
);

  // Prescaler needs at least one bit even when every cycle is a tick.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_div_last = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q,     presc_d;
  logic [WIDTH-1:0]    time_q,      time_d;
  logic [DAY_W-1:0]    day_q,       day_d;
  logic                tick_q,      tick_d;
  logic                day_end_q,   day_end_d;
  logic [N_ALARMS-1:0] alarm_hit_q, alarm_hit_d;

  logic                w_tick_evt;
  logic                w_wrap;
  logic [WIDTH-1:0]    w_next;
  logic [WIDTH-1:0]    w_period_m1;

  // Next-state logic: load beats tick, tick beats hold; pulses default low.
  always_comb begin
    presc_d     = presc_q;
    time_d      = time_q;
    day_d       = day_q;
    tick_d      = 1'b0;
    day_end_d   = 1'b0;
    alarm_hit_d = '0;

    w_tick_evt  = en && (presc_q == c_div_last);
    w_period_m1 = period - WIDTH'(1);
    // ">=" rather than "==" so a period shrunk below the current minute
    // wraps on the very next tick instead of running to 2^WIDTH.
    w_wrap      = (period != '0) ? (time_q >= w_period_m1) : (&time_q);
    w_next      = w_wrap ? '0 : time_q + WIDTH'(1);

    if (load) begin
      presc_d = '0;
      time_d  = ((period != '0) && (load_value >= period)) ? '0 : load_value;
    end else if (en) begin
      presc_d = w_tick_evt ? '0 : presc_q + PW'(1);
      if (w_tick_evt) begin
        tick_d = 1'b1;
        time_d = w_next;
        if (w_wrap) begin
          day_end_d = 1'b1;
          day_d     = day_q + DAY_W'(1);
        end
        for (int k = 0; k < N_ALARMS; k++) begin
          alarm_hit_d[k] = alarm_en[k] && (w_next == alarm_time[k*WIDTH +: WIDTH]);
        end
      end
    end
  end

  // State and output registers; asynchronous clear drops any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      time_q      <= '0;
      day_q       <= '0;
      tick_q      <= 1'b0;
      day_end_q   <= 1'b0;
      alarm_hit_q <= '0;
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      day_q       <= day_d;
      tick_q      <= tick_d;
      day_end_q   <= day_end_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign tick      = tick_q;
  assign time_out  = time_q;
  assign day_end   = day_end_q;
  assign day_count = day_q;
  assign alarm_hit = alarm_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_day_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_day_timer_multi
//  Description : Self-checking bench for day_timer_multi. Directed scenarios
//                followed by random stimulus, compared every cycle against a
//                behavioural minute/day model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_day_timer_multi;

  localparam int W  = 4;
  localparam int TD = 3;
  localparam int NA = 4;
  localparam int DW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [W-1:0]     period;
  logic             load;
  logic [W-1:0]     load_value;
  logic [NA*W-1:0]  alarm_time;
  logic [NA-1:0]    alarm_en;
  logic             tick;
  logic [W-1:0]     time_out;
  logic             day_end;
  logic [DW-1:0]    day_count;
  logic [NA-1:0]    alarm_hit;

  day_timer_multi #(
    .WIDTH(W), .TICK_DIV(TD), .N_ALARMS(NA), .DAY_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .load(load),
    .load_value(load_value), .alarm_time(alarm_time), .alarm_en(alarm_en),
    .tick(tick), .time_out(time_out), .day_end(day_end),
    .day_count(day_count), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_presc, m_time, m_day, m_tick, m_dend, m_hit;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_time = 0; m_day = 0; m_tick = 0; m_dend = 0; m_hit = 0;
  endtask

  // One clock edge of the minute/day timer, from the rules in plain arithmetic.
  task automatic model_edge();
    int day_len, nxt;
    day_len = (period == 0) ? (1 << W) : int'(period);
    m_tick = 0; m_dend = 0; m_hit = 0;
    if (load) begin
      m_presc = 0;
      m_time  = (period != 0 && load_value >= period) ? 0 : int'(load_value);
    end else if (en) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        m_tick  = 1;
        if (m_time >= day_len - 1) begin
          nxt    = 0;
          m_dend = 1;
          m_day  = (m_day + 1) % (1 << DW);
        end else begin
          nxt = m_time + 1;
        end
        m_time = nxt;
        for (int k = 0; k < NA; k++)
          if (alarm_en[k] && int'(alarm_time[k*W +: W]) == nxt) m_hit |= (1 << k);
      end else begin
        m_presc++;
      end
    end
  endtask

  task automatic check_all();
    chk("tick",      32'(tick),      32'(m_tick));
    chk("time_out",  32'(time_out),  32'(m_time));
    chk("day_end",   32'(day_end),   32'(m_dend));
    chk("day_count", 32'(day_count), 32'(m_day));
    chk("alarm_hit", 32'(alarm_hit), 32'(m_hit));
  endtask

  // Inputs are changed only after a falling edge, so they are stable here.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; en = 1'b0; period = 4'd5; load = 1'b0; load_value = '0;
    alarm_time = '0; alarm_en = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic counting, period 5
    en = 1'b1;
    run(40);

    // Pause mid-minute: prescaler phase must be kept
    period = 4'd3;
    run(2);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(30);

    // Alarms: ch0 at 0 (with day_end), ch1/ch2 at 3, ch3 at 12 never (period 10)
    period     = 4'd10;
    alarm_time = {4'd12, 4'd3, 4'd3, 4'd0};
    alarm_en   = 4'b1111;
    run(40);
    alarm_en   = 4'b1101;
    run(40);

    // Load coinciding with a tick at minute 7: tick is discarded
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_time == 7 && m_presc == TD - 1) found = 1'b1;
      else step();
    end
    chk("reach_min7", 32'(found), 32'd1);
    load = 1'b1; load_value = 4'd2;
    step();
    load_value = 4'd15;
    step();
    load = 1'b0;
    run(10);

    // Period shrunk below the current minute wraps on the next tick
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_time == 6) found = 1'b1;
      else step();
    end
    chk("reach_min6", 32'(found), 32'd1);
    period = 4'd4;
    run(10);

    // period 0 means a full 2^W-minute day
    period = 4'd0;
    run(60);

    // Short days drive the day counter through its wrap
    period = 4'd2;
    run(60);

    // Asynchronous reset between edges
    run(4);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    period = 4'd5;
    run(15);

    // Randomised stimulus
    for (int i = 0; i < 800; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      load_value = W'($urandom);
      if ($urandom_range(0, 29) == 0) period = W'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) alarm_time = (NA*W)'($urandom);
      if ($urandom_range(0, 19) == 0) alarm_en = NA'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/day_timer_multi.md
Name: day_timer_multi

Overview:
- Parametrised successor to the seating-system minute timer.
- Prescales the system clock into minute ticks and counts minutes within a run-time-programmable day length.
- At wrap it emits a one-cycle day-end pulse and advances a day counter.
- Adds enable/pause, synchronous preload and N independent alarm channels, which drive seat-reservation expiry and period-change events downstream.

Parameters:
- WIDTH, 11, width of minute counter, period and alarm compare values.
- TICK_DIV, 1, clk cycles per minute tick; must be >= 1; 1 = count every enabled cycle.
- N_ALARMS, 4, number of alarm channels; must be >= 1.
- DAY_W, 8, width of day counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; 0 freezes prescaler and minute counter.
- period  in  WIDTH  day length in minutes; counter runs 0..period-1; 0 means 2^WIDTH.
- load  in  1  synchronous preload strobe.
- load_value  in  WIDTH  minute value applied on load.
- alarm_time  in  N_ALARMS*WIDTH  packed compare values; channel k = bits [k*WIDTH +: WIDTH].
- alarm_en  in  N_ALARMS  per-channel alarm enable.
- tick  out  1  one-cycle pulse on each minute tick.
- time_out  out  WIDTH  current minute.
- day_end  out  1  one-cycle pulse when the minute counter wraps to 0.
- day_count  out  DAY_W  days elapsed, modulo 2^DAY_W.
- alarm_hit  out  N_ALARMS  one-cycle pulse per channel.

Behaviour:
- Reset (async assert, sync deassert in use): prescaler=0, time_out=0, day_count=0, tick=0, day_end=0, alarm_hit=0.
- All outputs are registered; no combinational input-to-output path.
- Prescaler: when en=1, counts 0..TICK_DIV-1. The cycle it equals TICK_DIV-1 it returns to 0 and a minute tick occurs. With TICK_DIV=1, every enabled cycle is a tick.
- The tick output registers the tick event; time_out, day_end and alarm_hit update on that same edge.
- Priority per cycle: reset > load > tick > hold.
- Load: time_out <= load_value and prescaler <= 0. If period != 0 and load_value >= period, time_out <= 0 instead.
  - No day_end, no alarm_hit, no tick, day_count unchanged.
  - Load works regardless of en.
  - A tick coinciding with load is discarded.
- Tick, normal case: next = time_out+1.
- Tick, wrap case: applies if period != 0 and time_out >= period-1, or if period == 0 and time_out is all-ones. Then next = 0, day_end=1 for that cycle, and day_count <= day_count+1 (wraps modulo 2^DAY_W).
- The >= compare covers period being reduced below the current time_out mid-day: the next tick wraps immediately.
- Alarms: on a tick (not a load), alarm_hit[k]=1 iff alarm_en[k]=1 and next == alarm_time[k].
  - Multiple channels may fire in the same cycle.
  - An alarm_time of 0 fires together with day_end.
  - An alarm_time >= period never fires.
- en=0: all counters hold and all pulses are 0. Prescaler phase is preserved, so a pause does not restart the minute.
- period may change at any time and takes effect at the next tick compare.
- Reset asserted mid-day clears everything immediately. Pulses in flight are dropped.

Test Plan:
1. TICK_DIV=1, period=5, en=1 for 12 cycles -> time_out 1,2,3,4,0,1,2,3,4,0,1,2; day_end high on cycles 5 and 10; day_count=2.
2. TICK_DIV=4, period=3, en toggled 0 for 3 cycles after the 2nd clock -> tick every 4 enabled cycles; prescaler phase is held; first day_end after 12 enabled cycles.
3. Alarms: period=10, alarm_time={0,3,3,12}, alarm_en=4'b1111 -> ch1 and ch2 pulse together when time_out becomes 3; ch0 pulses with day_end; ch3 never pulses. Then alarm_en[1]=0 -> only ch2 fires at 3.
4. Load: at time_out=7, assert load with load_value=2 simultaneously with a tick -> time_out=2 next cycle, no tick/day_end/alarm pulse. load_value=15 with period=10 -> time_out=0.
5. Period shrink and period=0: period 10 -> 4 while time_out=6 -> next tick gives time_out=0 and day_end=1. period=0 with WIDTH=3 -> counts 0..7 and wraps with day_end. day_count at 255 wraps to 0 with DAY_W=8.
6. Async reset: assert rst_n=0 mid-cycle with no clock edge -> all outputs 0 immediately. After release -> counting resumes from 0 on the first full prescale period.
